// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter that shares one APB bus among NUM_REQ requesters.
// Runs SETUP/ACCESS, returns read data and status, and terminates hung slaves.
module apb_rr_master_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          err,
    output logic                          tout,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR,
    input  logic [DATA_WIDTH-1:0]         PRDATA
);

    localparam int unsigned PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
    localparam logic [PW-1:0] PTR_MAX = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e                  state;
    logic [PW-1:0]           ptr;
    logic [CW-1:0]           wait_cnt;

    logic [NUM_REQ-1:0]      eligible;
    logic                    pick_valid;
    logic [PW-1:0]           pick_idx;
    logic [PW-1:0]           cand;
    logic [NUM_REQ-1:0]      pick_onehot;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    logic [DATA_WIDTH-1:0]   pick_wdata;
    logic                    pick_write;
    logic                    timeout_hit;

    // The requester that completed this cycle is masked so it cannot win back-to-back.
    assign eligible = req & ~done;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == PTR_MAX) ? '0 : cand + 1'b1;
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        pick_onehot = '0;
        pick_addr   = '0;
        pick_wdata  = '0;
        pick_write  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == PW'(i)) begin
                pick_onehot[i] = pick_valid;
                pick_addr      = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_wdata     = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                pick_write     = req_write[i];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= StIdle;
            ptr      <= PTR_MAX;
            wait_cnt <= '0;
            gnt      <= '0;
            done     <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            tout     <= 1'b0;
            PADDR    <= '0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PWDATA   <= '0;
        end else begin
            done <= '0;
            unique case (state)
                StIdle: begin
                    if (pick_valid) begin
                        gnt     <= pick_onehot;
                        ptr     <= pick_idx;
                        PADDR   <= pick_addr;
                        PWRITE  <= pick_write;
                        PWDATA  <= pick_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= StSetup;
                    end
                end
                StSetup: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= StAccess;
                end
                StAccess: begin
                    if (PREADY) begin
                        if (!PWRITE) begin
                            rdata <= PRDATA;
                        end
                        err     <= PSLVERR;
                        tout    <= 1'b0;
                        done    <= gnt;
                        gnt     <= '0;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= StIdle;
                    end else if (timeout_hit) begin
                        err     <= 1'b1;
                        tout    <= 1'b1;
                        done    <= gnt;
                        gnt     <= '0;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    gnt_onehot: assert property (@(posedge PCLK) $onehot0(gnt));
    done_onehot: assert property (@(posedge PCLK) $onehot0(done));
    enable_within_select: assert property (@(posedge PCLK) PENABLE |-> PSEL);

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Bench for apb_rr_master_arbiter: directed plan tests with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_apb_rr_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int TO = 16;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            tout;
    logic [AW-1:0]   PADDR;
    logic            PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [DW-1:0]   PWDATA;
    logic            PREADY;
    logic            PSLVERR;
    logic [DW-1:0]   PRDATA;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: owner index (-1 when bus free), access-cycle number, rr pointer.
    int            m_owner;
    int            m_phase;
    int            m_ptr;
    logic [N-1:0]  e_gnt, e_done;
    logic [DW-1:0] e_rdata, e_pwdata;
    logic [AW-1:0] e_paddr;
    logic          e_err, e_tout, e_psel, e_penable, e_pwrite;

    apb_rr_master_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_REQ   (N),
        .TIMEOUT   (TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .req      (req),
        .req_addr (req_addr),
        .req_write(req_write),
        .req_wdata(req_wdata),
        .gnt      (gnt),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .tout     (tout),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .PRDATA   (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_xfer();
        e_done          = '0;
        e_done[m_owner] = 1'b1;
        e_gnt           = '0;
        e_psel          = 1'b0;
        e_penable       = 1'b0;
        m_owner         = -1;
    endtask

    task automatic model_step();
        logic [N-1:0] cur_done;
        if (PRESET) begin
            m_owner = -1; m_phase = 0; m_ptr = N - 1;
            e_gnt = '0; e_done = '0; e_rdata = '0; e_err = 0; e_tout = 0;
            e_paddr = '0; e_psel = 0; e_penable = 0; e_pwrite = 0; e_pwdata = '0;
            return;
        end
        cur_done = e_done;
        e_done   = '0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (req[idx] && !cur_done[idx]) begin
                    m_owner    = idx;
                    m_ptr      = idx;
                    m_phase    = 0;
                    e_paddr    = req_addr[idx*AW +: AW];
                    e_pwdata   = req_wdata[idx*DW +: DW];
                    e_pwrite   = req_write[idx];
                    e_psel     = 1'b1;
                    e_penable  = 1'b0;
                    e_gnt      = '0;
                    e_gnt[idx] = 1'b1;
                    break;
                end
            end
        end else if (m_phase == 0) begin
            e_penable = 1'b1;
            m_phase   = 1;
        end else if (PREADY) begin
            if (!e_pwrite) e_rdata = PRDATA;
            e_err  = PSLVERR;
            e_tout = 1'b0;
            finish_xfer();
        end else if (TO > 0 && m_phase == TO) begin
            e_err  = 1'b1;
            e_tout = 1'b1;
            finish_xfer();
        end else begin
            m_phase++;
        end
    endtask

    task automatic compare_all();
        chk("gnt", gnt, e_gnt);
        chk("done", done, e_done);
        chk("rdata", rdata, e_rdata);
        chk("err", err, e_err);
        chk("tout", tout, e_tout);
        chk("paddr", PADDR, e_paddr);
        chk("psel", PSEL, e_psel);
        chk("penable", PENABLE, e_penable);
        chk("pwrite", PWRITE, e_pwrite);
        chk("pwdata", PWDATA, e_pwdata);
    endtask

    task automatic tick();
        @(posedge PCLK);
        model_step();
        @(negedge PCLK);
        compare_all();
    endtask

    task automatic wait_done(input int idx, input int budget, output int pe_cycles);
        bit seen;
        seen      = 0;
        pe_cycles = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            tick();
            if (PENABLE) pe_cycles++;
            if (done[idx]) begin
                seen     = 1;
                req[idx] = 1'b0;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d);
        req_addr[idx*AW +: AW]  = a;
        req_wdata[idx*DW +: DW] = d;
        req_write[idx]          = w;
        req[idx]                = 1'b1;
    endtask

    initial begin
        int pe;
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] prev_g;
        bit hang;

        PRESET = 1'b1; req = '0; req_addr = '0; req_write = '0; req_wdata = '0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        tick();
        tick();
        chk("reset_psel", 64'(PSEL), 64'd0);
        chk("reset_gnt", 64'(gnt), 64'd0);
        PRESET = 1'b0;
        tick();

        // Single write with PREADY tied high.
        PREADY = 1'b1;
        set_req(0, 32'h10, 1'b1, 32'hDEADBEEF);
        tick();
        chk("t1_psel_c1", 64'(PSEL), 64'd1);
        chk("t1_pen_c1", 64'(PENABLE), 64'd0);
        chk("t1_gnt_c1", 64'(gnt), 64'h1);
        tick();
        chk("t1_pen_c2", 64'(PENABLE), 64'd1);
        chk("t1_paddr", 64'(PADDR), 64'h10);
        chk("t1_pwdata", 64'(PWDATA), 64'hDEADBEEF);
        chk("t1_pwrite", 64'(PWRITE), 64'd1);
        tick();
        chk("t1_done_c3", 64'(done), 64'h1);
        chk("t1_psel_c3", 64'(PSEL), 64'd0);
        chk("t1_err", 64'(err), 64'd0);
        req[0] = 1'b0;
        tick();
        chk("t1_done_c4", 64'(done), 64'h0);

        // Read with three wait states.
        PREADY = 1'b0;
        PRDATA = 32'hA5A50001;
        set_req(2, 32'h24, 1'b0, 32'h0);
        pe = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (PENABLE) pe++;
            if (done[2]) req[2] = 1'b0;
            PREADY = (pe == 4);
        end
        chk("t2_pen_cycles", 64'(pe), 64'd4);
        chk("t2_rdata", 64'(rdata), 64'hA5A50001);

        // Slave error on a read.
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h1234;
        set_req(1, 32'h30, 1'b0, 32'h0);
        wait_done(1, 10, pe);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_tout", 64'(tout), 64'd0);
        chk("t4_rdata", 64'(rdata), 64'h1234);
        PSLVERR = 1'b0;

        // Timeout with PREADY stuck low.
        PREADY = 1'b0; PRDATA = 32'hFFFF0000;
        set_req(3, 32'h40, 1'b0, 32'h0);
        wait_done(3, 40, pe);
        chk("t5_pen_cycles", 64'(pe), 64'd16);
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_tout", 64'(tout), 64'd1);
        chk("t5_rdata", 64'(rdata), 64'h1234);
        chk("t5_psel", 64'(PSEL), 64'd0);

        // Round robin with all requesters held.
        PREADY = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, AW'(32'h100 + i * 4), 1'b1, DW'(i));
        prev_g = '0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            tick();
            if (gnt != '0 && prev_g == '0)
                for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
            prev_g = gnt;
        end
        chk("t3_grants", 64'(order.size()), 64'd5);
        for (int j = 0; j < 5; j++)
            chk("t3_order", (j < order.size()) ? 64'(order[j]) : 64'hFF, 64'(exp_order[j]));
        req = 4'b0001;
        wait_done(0, 10, pe);

        // Reset in the middle of an access.
        PREADY = 1'b0;
        set_req(2, 32'h50, 1'b1, 32'h5555);
        for (int c = 0; c < 10 && !PENABLE; c++) tick();
        chk("t6_in_access", 64'(PENABLE), 64'd1);
        PRESET = 1'b1;
        tick();
        chk("t6_psel", 64'(PSEL), 64'd0);
        chk("t6_penable", 64'(PENABLE), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_rdata", 64'(rdata), 64'd0);
        chk("t6_err", 64'(err), 64'd0);
        PRESET = 1'b0;
        req = 4'b0000;
        set_req(1, 32'h60, 1'b1, 32'h6666);
        PREADY = 1'b1;
        tick();
        chk("t6_gnt_after", 64'(gnt), 64'h2);
        wait_done(1, 10, pe);

        // Randomized traffic.
        hang = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            PRESET = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (done[i]) req[i] = ($urandom_range(0, 1) == 1);
                else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
                req_addr[i*AW +: AW]  = $urandom();
                req_wdata[i*DW +: DW] = $urandom();
                req_write[i]          = $urandom_range(0, 1);
            end
            if (PSEL && !PENABLE) hang = ($urandom_range(0, 9) == 0);
            PREADY  = hang ? 1'b0 : ($urandom_range(0, 2) == 0);
            PSLVERR = $urandom_range(0, 1);
            PRDATA  = $urandom();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_rr_master_arbiter.md
Name: apb_rr_master_arbiter

Overview:
Round-robin arbiter and APB master sequencer that shares one APB bus among NUM_REQ requesters.
- Accepts a transfer request (addr, write, wdata) from each requester and grants one at a time.
- Runs the APB SETUP/ACCESS protocol on PADDR/PSEL/PENABLE/PWRITE/PWDATA.
- Returns PRDATA/PSLVERR to the granted requester with a one-cycle done pulse.
- Terminates hung slaves with a PREADY timeout.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables timeout

Ports:
PCLK  input  1  clock, all logic on rising edge
PRESET  input  1  synchronous active-high reset
req  input  NUM_REQ  per-requester transfer request, held until its done
req_addr  input  NUM_REQ*ADDR_WIDTH  requester i address in slice i
req_write  input  NUM_REQ  1=write, 0=read
req_wdata  input  NUM_REQ*DATA_WIDTH  requester i write data in slice i
gnt  output  NUM_REQ  one-hot, high from grant through completion
done  output  NUM_REQ  one-cycle completion pulse to granted requester
rdata  output  DATA_WIDTH  read data of last completed read
err  output  1  error status of last completion (PSLVERR or timeout)
tout  output  1  last completion was a timeout
PADDR  output  ADDR_WIDTH  APB address
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PREADY  input  1  slave ready
PSLVERR  input  1  slave error, valid when PREADY high in ACCESS
PRDATA  input  DATA_WIDTH  slave read data, valid when PREADY high in ACCESS

Behaviour:
- Interface: one clock PCLK; reset PRESET is synchronous and active-high.
- All outputs are registered.
- Reset state:
  - All outputs are 0. The state machine is IDLE.
  - The round-robin pointer is NUM_REQ-1, so requester 0 has highest priority first.
  - Asserting PRESET mid-transfer aborts the transfer: PSEL and PENABLE drop the next edge and no done pulse is issued.
- FSM states are IDLE, SETUP and ACCESS.
- IDLE:
  - Eligible requesters are req & ~done, which masks the requester that completed this cycle.
  - If any requester is eligible, pick the first eligible index searching upward, with wrap, from pointer+1.
  - Latch that requester's addr/write/wdata into PADDR/PWRITE/PWDATA and set gnt[i], PSEL=1, PENABLE=0. Pointer becomes i. Go to SETUP.
  - If no requester is eligible, stay in IDLE with PSEL=0.
- SETUP: always lasts exactly one cycle. Set PENABLE=1 and go to ACCESS. PADDR/PWRITE/PWDATA stay stable through SETUP and ACCESS.
- ACCESS:
  - Wait-counter clears on entry.
  - PREADY=1: capture PRDATA into rdata (reads only; writes leave rdata unchanged). Set err=PSLVERR, tout=0, done[i]=1. Clear PSEL, PENABLE and gnt. Go to IDLE.
  - PREADY=0: the counter increments.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 with PREADY still low, terminate the same way with err=1, tout=1, rdata unchanged.
  - Maximum ACCESS length is TIMEOUT cycles.
- Latency:
  - req rises in cycle 0 on an idle bus: PSEL=1 in cycle 1, PENABLE=1 in cycle 2.
  - PREADY=1 sampled at the end of cycle 2 gives done=1 and PSEL=0 in cycle 3.
  - The next grant can appear in cycle 4. There is one idle bus cycle between transfers.
- PADDR/PWDATA hold their last values while idle.
- Changes to req or requester inputs after grant are ignored until completion.
- A deasserted req in IDLE is simply not eligible.
- done and gnt never assert for more than one requester at a time.
- PSLVERR is ignored outside ACCESS with PREADY high.

Test Plan:
1. Single write: req[0]=1, addr=0x10, wdata=0xDEADBEEF, PREADY tied 1 -> PSEL rises in cycle 1, PENABLE in cycle 2, done[0] in cycle 3, err=0, PADDR=0x10, PWDATA=0xDEADBEEF throughout.
2. Read with wait states: req[2] read at 0x24, PREADY low 3 ACCESS cycles then high with PRDATA=0xA5A5_0001 -> rdata=0xA5A5_0001, done[2] one cycle, PENABLE high 4 cycles.
3. Round robin: req=4'b1111 held, each requester re-asserting after its done -> grant order 0,1,2,3,0; no requester granted twice consecutively while others wait.
4. Slave error: read with PREADY=1, PSLVERR=1, PRDATA=0x1234 -> err=1, tout=0, rdata=0x1234, done pulsed.
5. Timeout: TIMEOUT=16, PREADY held 0 -> PENABLE high exactly 16 cycles, then done, err=1, tout=1, rdata unchanged, PSEL low.
6. Reset mid-transfer: PRESET=1 during ACCESS -> next edge all outputs 0, no done; after release req[1] alone is granted first.
